// File: rtl/hex_sched_pkg.sv
// rtl/hex_sched_pkg.sv - shared types and defaults for the hexagon bumper scheduler
//
// Holds the coordinate width, the default table size and tester latency,
// the scheduler FSM state type and the bumper table entry layout.
package hex_sched_pkg;

    localparam int COORD_W      = 10;
    localparam int N_OBJ_DEF    = 4;
    localparam int TEST_LAT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] xc;
        logic [COORD_W-1:0] yc;
        logic               en;
    } entry_t;

endpackage

// File: rtl/hex_tag_pipe.sv
// rtl/hex_tag_pipe.sv - fixed-depth {valid, idx} delay line that tracks tester requests in flight
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   in_valid_i, in_idx_i tag entering alongside the registered tester operands
//   out_valid_o, out_idx_o tag aligned with the tester result DEPTH cycles later
//   inflight_o           a tag is still travelling and will retire on a later cycle
module hex_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int IW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    input  logic [IW-1:0] in_idx_i,
    output logic          out_valid_o,
    output logic [IW-1:0] out_idx_o,
    output logic          inflight_o
);

    logic [DEPTH-1:0] vld_q;
    logic [IW-1:0]    idx_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid_i;
            idx_q[0] <= in_idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[DEPTH-1];
    assign out_idx_o   = idx_q[DEPTH-1];

    // The output stage is retiring this cycle, so only earlier stages count
    // as still outstanding.
    always_comb begin
        inflight_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            inflight_o = inflight_o | vld_q[i];
        end
    end

endmodule

// File: rtl/hex_bumper_sched.sv
// rtl/hex_bumper_sched.sv - time-multiplexes one hexagon hit-tester across a bumper table per pixel
//
// Ports:
//   CLK, RSTn                      clock, asynchronous active-low reset
//   pix_valid/pix_ready, pix_x/y   pixel request handshake and coordinate
//   cfg_we/cfg_ready, cfg_idx,
//   cfg_xc/yc, cfg_en              bumper table write port
//   tst_x/y/xc/yc, tst_hit         operands to and result from the shared tester
//   res_valid, res_mask, res_hit,
//   res_idx                        per-pixel result, held until the next result
//   busy                           scheduler is working on a pixel
module hex_bumper_sched
    import hex_sched_pkg::*;
#(
    parameter int N_OBJ    = N_OBJ_DEF,
    parameter int TEST_LAT = TEST_LAT_DEF,
    localparam int IW      = $clog2(N_OBJ)
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               cfg_we,
    output logic               cfg_ready,
    input  logic [IW-1:0]      cfg_idx,
    input  logic [COORD_W-1:0] cfg_xc,
    input  logic [COORD_W-1:0] cfg_yc,
    input  logic               cfg_en,
    output logic [COORD_W-1:0] tst_x,
    output logic [COORD_W-1:0] tst_y,
    output logic [COORD_W-1:0] tst_xc,
    output logic [COORD_W-1:0] tst_yc,
    input  logic               tst_hit,
    output logic               res_valid,
    output logic [N_OBJ-1:0]   res_mask,
    output logic               res_hit,
    output logic [IW-1:0]      res_idx,
    output logic               busy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_OBJ - 1);

    state_t             state_q, state_d;
    logic [IW-1:0]      cnt_q, cnt_d;
    entry_t             tbl_q [N_OBJ];
    logic [N_OBJ-1:0]   tbl_en;
    logic [N_OBJ-1:0]   en_snap_q;
    logic [COORD_W-1:0] tst_x_q, tst_y_q, tst_xc_q, tst_yc_q;
    logic [N_OBJ-1:0]   mask_q, mask_d;
    logic [N_OBJ-1:0]   res_mask_q;
    logic               res_hit_q;
    logic [IW-1:0]      res_idx_q, prio_idx;
    logic               pend_vld_q;
    logic [IW-1:0]      pend_idx_q;
    entry_t             pend_ent_q;
    entry_t             cfg_ent;

    logic               accept, load_tst, enter_done;
    logic [IW-1:0]      load_idx;
    logic               tbl_we;
    logic [IW-1:0]      tbl_wi;
    entry_t             tbl_wd;
    logic               pend_take;

    logic               tag_vld;
    logic [IW-1:0]      tag_idx;
    logic               tag_inflight;

    assign cfg_ent.xc = cfg_xc;
    assign cfg_ent.yc = cfg_yc;
    assign cfg_ent.en = cfg_en;

    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            tbl_en[i] = tbl_q[i].en;
        end
    end

    // Scheduler FSM: the tester operands for entry k are loaded on the edge
    // that ends the previous cycle, so entry k is presented while cnt_q == k.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        load_tst   = 1'b0;
        load_idx   = cnt_q + IW'(1);
        enter_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_valid) begin
                    state_d  = ISSUE;
                    accept   = 1'b1;
                    load_tst = 1'b1;
                    load_idx = '0;
                    cnt_d    = '0;
                end
            end
            ISSUE: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    load_tst = 1'b1;
                    cnt_d    = cnt_q + IW'(1);
                end
            end
            DRAIN: begin
                if (!tag_inflight) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    hex_tag_pipe #(
        .DEPTH (TEST_LAT),
        .IW    (IW)
    ) u_tag_pipe (
        .clk_i       (CLK),
        .rst_ni      (RSTn),
        .in_valid_i  (state_q == ISSUE),
        .in_idx_i    (cnt_q),
        .out_valid_o (tag_vld),
        .out_idx_o   (tag_idx),
        .inflight_o  (tag_inflight)
    );

    // Fold the retiring tag into the mask; the result registers take the
    // folded value so the final retirement lands in the same edge as DONE.
    always_comb begin
        mask_d = mask_q;
        if (tag_vld) begin
            mask_d[tag_idx] = tst_hit & en_snap_q[tag_idx];
        end
    end

    always_comb begin
        prio_idx = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (mask_d[i]) begin
                prio_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tst_x_q    <= '0;
            tst_y_q    <= '0;
            tst_xc_q   <= '0;
            tst_yc_q   <= '0;
            en_snap_q  <= '0;
            mask_q     <= '0;
            res_mask_q <= '0;
            res_hit_q  <= 1'b0;
            res_idx_q  <= '0;
        end else begin
            if (accept) begin
                tst_x_q   <= pix_x;
                tst_y_q   <= pix_y;
                en_snap_q <= tbl_en;
            end
            if (load_tst) begin
                tst_xc_q <= tbl_q[load_idx].xc;
                tst_yc_q <= tbl_q[load_idx].yc;
            end
            mask_q <= accept ? '0 : mask_d;
            if (enter_done) begin
                res_mask_q <= mask_d;
                res_hit_q  <= |mask_d;
                res_idx_q  <= prio_idx;
            end
        end
    end

    // Table writes land immediately in IDLE. While busy a single write is
    // parked and replayed on the DONE->IDLE edge, so the table is frozen for
    // the whole pixel. A write offered during DONE itself goes straight in.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_wi    = cfg_idx;
        tbl_wd    = cfg_ent;
        pend_take = 1'b0;
        if (state_q == IDLE) begin
            tbl_we = cfg_we;
        end else if (state_q == DONE) begin
            if (pend_vld_q) begin
                tbl_we = 1'b1;
                tbl_wi = pend_idx_q;
                tbl_wd = pend_ent_q;
            end else begin
                tbl_we = cfg_we;
            end
        end else begin
            pend_take = cfg_we & ~pend_vld_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < N_OBJ; i++) begin
                tbl_q[i] <= '0;
            end
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            pend_ent_q <= '0;
        end else begin
            if (tbl_we) begin
                tbl_q[tbl_wi] <= tbl_wd;
            end
            if (state_q == DONE) begin
                pend_vld_q <= 1'b0;
            end else if (pend_take) begin
                pend_vld_q <= 1'b1;
                pend_idx_q <= cfg_idx;
                pend_ent_q <= cfg_ent;
            end
        end
    end

    assign pix_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cfg_ready = ~pend_vld_q;
    assign res_valid = (state_q == DONE);
    assign res_mask  = res_mask_q;
    assign res_hit   = res_hit_q;
    assign res_idx   = res_idx_q;
    assign tst_x     = tst_x_q;
    assign tst_y     = tst_y_q;
    assign tst_xc    = tst_xc_q;
    assign tst_yc    = tst_yc_q;

endmodule

// File: tb/tb_hex_bumper_sched.sv
// tb/tb_hex_bumper_sched.sv - self-checking bench for hex_bumper_sched
module tb_hex_bumper_sched;

    localparam int N       = 4;
    localparam int LAT     = 3;
    localparam int IW      = 2;
    localparam int RES_CYC = N + LAT + 1;

    logic          CLK  = 1'b0;
    logic          RSTn = 1'b1;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [9:0]    pix_x = '0, pix_y = '0;
    logic          cfg_we = 1'b0;
    logic          cfg_ready;
    logic [IW-1:0] cfg_idx = '0;
    logic [9:0]    cfg_xc = '0, cfg_yc = '0;
    logic          cfg_en = 1'b0;
    logic [9:0]    tst_x, tst_y, tst_xc, tst_yc;
    logic          tst_hit;
    logic          res_valid;
    logic [N-1:0]  res_mask;
    logic          res_hit;
    logic [IW-1:0] res_idx;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    hex_bumper_sched #(.N_OBJ(N), .TEST_LAT(LAT)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_xc    (cfg_xc),
        .cfg_yc    (cfg_yc),
        .cfg_en    (cfg_en),
        .tst_x     (tst_x),
        .tst_y     (tst_y),
        .tst_xc    (tst_xc),
        .tst_yc    (tst_yc),
        .tst_hit   (tst_hit),
        .res_valid (res_valid),
        .res_mask  (res_mask),
        .res_hit   (res_hit),
        .res_idx   (res_idx),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    function automatic bit near(input int a, input int b);
        return ((a - b) <= 5) && ((b - a) <= 5);
    endfunction

    // Shared tester: hit TEST_LAT cycles after the operands are presented.
    logic [LAT-1:0] hit_sr = '0;
    always @(posedge CLK)
        hit_sr <= {hit_sr[LAT-2:0], near(int'(tst_x), int'(tst_xc)) && near(int'(tst_y), int'(tst_yc))};
    assign tst_hit = hit_sr[LAT-1];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycle count since acceptance, table copy, pending write.
    int     m_cnt = 0;
    int     m_xc[N], m_yc[N];
    bit     m_en[N];
    int     s_xc[N], s_yc[N];
    bit [N-1:0] m_exp = '0;
    bit     m_pend = 0;
    int     m_pi = 0, m_pxc = 0, m_pyc = 0;
    bit     m_pen = 0;
    int     m_tx = 0, m_ty = 0, m_txc = 0, m_tyc = 0;
    bit [N-1:0] m_res = '0;
    int     m_ridx = 0;

    initial begin
        for (int k = 0; k < N; k++) begin m_xc[k] = 0; m_yc[k] = 0; m_en[k] = 0; end
        forever begin
            @(posedge CLK);
            if (!RSTn) begin
                m_cnt = 0; m_pend = 0; m_res = '0; m_ridx = 0;
                m_tx = 0; m_ty = 0; m_txc = 0; m_tyc = 0;
                for (int k = 0; k < N; k++) begin m_xc[k] = 0; m_yc[k] = 0; m_en[k] = 0; end
            end else if (m_cnt == 0) begin
                if (pix_valid) begin
                    m_exp = '0;
                    for (int k = 0; k < N; k++) begin
                        s_xc[k] = m_xc[k]; s_yc[k] = m_yc[k];
                        if (m_en[k] && near(int'(pix_x), m_xc[k]) && near(int'(pix_y), m_yc[k]))
                            m_exp[k] = 1'b1;
                    end
                    m_tx = int'(pix_x); m_ty = int'(pix_y);
                    m_txc = s_xc[0]; m_tyc = s_yc[0];
                    m_cnt = 1;
                end
                if (cfg_we) begin
                    m_xc[cfg_idx] = int'(cfg_xc); m_yc[cfg_idx] = int'(cfg_yc); m_en[cfg_idx] = cfg_en;
                end
            end else begin
                if (cfg_we && !m_pend) begin
                    m_pend = 1; m_pi = int'(cfg_idx); m_pxc = int'(cfg_xc); m_pyc = int'(cfg_yc); m_pen = cfg_en;
                end
                if (m_cnt == RES_CYC) begin
                    if (m_pend) begin m_xc[m_pi] = m_pxc; m_yc[m_pi] = m_pyc; m_en[m_pi] = m_pen; end
                    m_pend = 0;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt <= N) begin m_txc = s_xc[m_cnt-1]; m_tyc = s_yc[m_cnt-1]; end
                    if (m_cnt == RES_CYC) begin
                        m_res = m_exp;
                        m_ridx = 0;
                        for (int k = N - 1; k >= 0; k--) if (m_exp[k]) m_ridx = k;
                    end
                end
            end
        end
    end

    // Compare process, away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (!RSTn) begin
            check("rst pix_ready", int'(pix_ready), 1);
            check("rst cfg_ready", int'(cfg_ready), 1);
            check("rst busy", int'(busy), 0);
            check("rst res_valid", int'(res_valid), 0);
            check("rst res_mask", int'(res_mask), 0);
            check("rst res_hit", int'(res_hit), 0);
            check("rst res_idx", int'(res_idx), 0);
            check("rst tst_xc", int'(tst_xc), 0);
            check("rst tst_x", int'(tst_x), 0);
        end else begin
            check("pix_ready", int'(pix_ready), int'(m_cnt == 0));
            check("busy", int'(busy), int'(m_cnt != 0));
            check("res_valid", int'(res_valid), int'(m_cnt == RES_CYC));
            check("cfg_ready", int'(cfg_ready), int'(!m_pend));
            check("res_mask", int'(res_mask), int'(m_res));
            check("res_hit", int'(res_hit), int'(m_res != 0));
            check("res_idx", int'(res_idx), m_ridx);
            check("tst_x", int'(tst_x), m_tx);
            check("tst_y", int'(tst_y), m_ty);
            check("tst_xc", int'(tst_xc), m_txc);
            check("tst_yc", int'(tst_yc), m_tyc);
        end
    end

    task automatic cfg_write(input int i, input int xc, input int yc, input bit en);
        cfg_we = 1'b1; cfg_idx = IW'(i); cfg_xc = 10'(xc); cfg_yc = 10'(yc); cfg_en = en;
        @(posedge CLK); #1;
        cfg_we = 1'b0;
    endtask

    // Starts at 1 time unit after an edge with the block idle; returns one
    // cycle after res_valid. wr_cyc < 0 means no config write.
    task automatic run_pixel(input int x, input int y, input bit [N-1:0] exp_mask, input int exp_idx,
                             input int wr_cyc, input int wi, input int wxc, input int wyc, input bit wen,
                             input bit chk_xc);
        int n;
        bit got;
        pix_x = 10'(x); pix_y = 10'(y); pix_valid = 1'b1;
        n = 0; got = 0;
        while (!got && n <= 20) begin
            if (n == wr_cyc) begin
                cfg_we = 1'b1; cfg_idx = IW'(wi); cfg_xc = 10'(wxc); cfg_yc = 10'(wyc); cfg_en = wen;
            end
            @(negedge CLK);
            if (chk_xc && n >= 1 && n <= N) check("lit tst_xc seq", int'(tst_xc), 11 * n);
            if (n > 0 && res_valid) begin
                got = 1;
            end else begin
                @(posedge CLK); #1;
                pix_valid = 1'b0; cfg_we = 1'b0;
                n++;
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL res_valid timeout: got none after %0d cycles, expected at cycle %0d", n, RES_CYC);
        end else begin
            check("lit latency", n, RES_CYC);
            check("lit res_mask", int'(res_mask), int'(exp_mask));
            check("lit res_hit", int'(res_hit), int'(exp_mask != 0));
            check("lit res_idx", int'(res_idx), exp_idx);
            if (wr_cyc > 0) check("lit cfg_ready at res", int'(cfg_ready), 0);
            @(posedge CLK); #1;
            if (wr_cyc > 0) check("lit cfg_ready after", int'(cfg_ready), 1);
        end
    endtask

    initial begin
        int acc[$];
        int nres;
        #1 RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RSTn = 1'b1;
        @(negedge CLK);
        check("lit reset pix_ready", int'(pix_ready), 1);
        check("lit reset busy", int'(busy), 0);
        check("lit reset res_mask", int'(res_mask), 0);
        @(posedge CLK); #1;

        // All entries disabled, distinct centres to watch the issue order.
        for (int k = 0; k < N; k++) cfg_write(k, 11 * (k + 1), 7, 1'b0);
        run_pixel(10, 10, 4'b0000, 0, -1, 0, 0, 0, 0, 1);

        cfg_write(1, 100, 200, 1'b1);
        cfg_write(3, 300, 200, 1'b1);
        run_pixel(301, 198, 4'b1000, 3, -1, 0, 0, 0, 0, 0);
        run_pixel(100, 200, 4'b0010, 1, -1, 0, 0, 0, 0, 0);

        cfg_write(0, 50, 50, 1'b1);
        cfg_write(2, 50, 50, 1'b1);
        run_pixel(50, 50, 4'b0101, 0, -1, 0, 0, 0, 0, 0);

        // Write during a pixel: parked, current result unchanged.
        run_pixel(50, 50, 4'b0101, 0, 3, 2, 400, 400, 1'b1, 0);
        run_pixel(400, 400, 4'b0100, 2, -1, 0, 0, 0, 0, 0);

        // Pixel and write together in IDLE: pixel sees the old table.
        run_pixel(300, 200, 4'b1000, 3, 0, 3, 300, 200, 1'b0, 0);
        run_pixel(300, 200, 4'b0000, 0, -1, 0, 0, 0, 0, 0);

        // Back-to-back requests.
        pix_x = 10'd50; pix_y = 10'd50; pix_valid = 1'b1;
        for (int c = 0; c < 28; c++) begin
            @(negedge CLK);
            if (pix_ready) acc.push_back(c);
            @(posedge CLK); #1;
        end
        pix_valid = 1'b0;
        check("lit b2b accepts", acc.size(), 4);
        for (int i = 1; i < acc.size(); i++) check("lit b2b spacing", acc[i] - acc[i-1], RES_CYC + 1);
        for (int c = 0; c < 20 && !pix_ready; c++) begin @(posedge CLK); #1; end
        check("lit b2b drained", int'(pix_ready), 1);

        // Reset mid-pixel with a parked write.
        pix_x = 10'd301; pix_y = 10'd198; pix_valid = 1'b1;
        @(posedge CLK); #1; pix_valid = 1'b0;
        @(posedge CLK); #1;
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_xc = 10'd301; cfg_yc = 10'd198; cfg_en = 1'b1;
        @(posedge CLK); #1; cfg_we = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RSTn = 1'b0;
        @(negedge CLK);
        check("lit midrst busy", int'(busy), 0);
        check("lit midrst cfg_ready", int'(cfg_ready), 1);
        check("lit midrst res_mask", int'(res_mask), 0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        nres = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (res_valid) nres++;
            @(posedge CLK); #1;
        end
        check("lit no res after reset", nres, 0);
        cfg_write(3, 300, 200, 1'b1);
        run_pixel(301, 198, 4'b1000, 3, -1, 0, 0, 0, 0, 0);
        run_pixel(301, 198, 4'b1000, 3, -1, 0, 0, 0, 0, 0);

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
